// File: rtl/wta_inhibit_ctrl.sv
// Winner-take-all lateral-inhibition controller: round-robin grant of one spiking
// neuron, timed inhibit window, winner handshake and saturating drop/suppression counters.
module wta_inhibit_ctrl #(
  parameter int NUM_NEURONS    = 4,
  parameter int IDX_W          = 2,
  parameter int CNT_W          = 4,
  parameter int INHIBIT_WINNER = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_NEURONS-1:0] spikes_in,
  input  logic [CNT_W-1:0]       refrac_len,
  output logic [NUM_NEURONS-1:0] lat_inhibit,
  output logic                   winner_valid,
  output logic [IDX_W-1:0]       winner_idx,
  input  logic                   winner_ready,
  output logic                   inhibit_active,
  output logic [7:0]             drop_count,
  output logic [7:0]             supp_count
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_INHIBIT = 1'b1
  } state_t;

  // First requesting neuron at or above ptr, wrapping modulo NUM_NEURONS.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_NEURONS-1:0] req,
                                               input logic [IDX_W-1:0]       ptr);
    logic [IDX_W-1:0] v_sel;
    logic             v_found;
    int               v_j;
    v_sel   = '0;
    v_found = 1'b0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      v_j = (int'(ptr) + k) % NUM_NEURONS;
      if (!v_found && req[v_j]) begin
        v_sel   = IDX_W'(v_j);
        v_found = 1'b1;
      end
    end
    return v_sel;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t                 r_state;
  logic [NUM_NEURONS-1:0] r_lat;
  logic                   r_valid;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_active;
  logic [7:0]             r_drop;
  logic [7:0]             r_supp;
  logic [IDX_W-1:0]       r_rr;
  logic [CNT_W-1:0]       r_cnt;

  state_t                 w_state_nxt;
  logic [NUM_NEURONS-1:0] w_lat_nxt;
  logic                   w_valid_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic                   w_active_nxt;
  logic [7:0]             w_drop_nxt;
  logic [7:0]             w_supp_nxt;
  logic [IDX_W-1:0]       w_rr_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;

  logic                   w_grant;
  logic                   w_xfer;
  logic [IDX_W-1:0]       w_winner;
  logic [NUM_NEURONS-1:0] w_mask;
  logic [CNT_W-1:0]       w_cnt_load;

  assign w_grant    = (r_state == ST_IDLE) && enable && (|spikes_in);
  assign w_xfer     = r_valid && winner_ready;
  assign w_winner   = rr_pick(spikes_in, r_rr);
  // A zero length still gives a one-cycle window.
  assign w_cnt_load = (refrac_len == '0) ? '0 : refrac_len - CNT_W'(1);

  // Inhibit pattern for the current winner.
  always_comb begin
    w_mask = '1;
    if (INHIBIT_WINNER == 0) begin
      w_mask[w_winner] = 1'b0;
    end else begin
      w_mask = '1;
    end
  end

  // Next-state, window timing, handshake and counter updates.
  always_comb begin
    w_state_nxt  = r_state;
    w_lat_nxt    = r_lat;
    w_valid_nxt  = r_valid;
    w_idx_nxt    = r_idx;
    w_active_nxt = r_active;
    w_drop_nxt   = r_drop;
    w_supp_nxt   = r_supp;
    w_rr_nxt     = r_rr;
    w_cnt_nxt    = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt  = ST_INHIBIT;
          w_lat_nxt    = w_mask;
          w_active_nxt = 1'b1;
          w_cnt_nxt    = w_cnt_load;
          if (w_winner == IDX_W'(NUM_NEURONS - 1)) begin
            w_rr_nxt = '0;
          end else begin
            w_rr_nxt = w_winner + IDX_W'(1);
          end
        end else begin
          w_lat_nxt    = '0;
          w_active_nxt = 1'b0;
        end
      end
      ST_INHIBIT: begin
        if (|spikes_in) begin
          w_supp_nxt = sat_inc8(r_supp);
        end else begin
          w_supp_nxt = r_supp;
        end
        if (!enable || (r_cnt == '0)) begin
          w_state_nxt  = ST_IDLE;
          w_lat_nxt    = '0;
          w_active_nxt = 1'b0;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_lat_nxt    = '0;
        w_active_nxt = 1'b0;
        w_cnt_nxt    = '0;
      end
    endcase

    // A grant that cannot be delivered still inhibits, but only the counter records it.
    if (w_grant) begin
      if (!r_valid || winner_ready) begin
        w_idx_nxt   = w_winner;
        w_valid_nxt = 1'b1;
      end else begin
        w_drop_nxt = sat_inc8(r_drop);
      end
    end else if (w_xfer) begin
      w_valid_nxt = 1'b0;
    end else begin
      w_valid_nxt = r_valid;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_lat    <= '0;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_active <= 1'b0;
      r_drop   <= 8'd0;
      r_supp   <= 8'd0;
      r_rr     <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_lat    <= w_lat_nxt;
      r_valid  <= w_valid_nxt;
      r_idx    <= w_idx_nxt;
      r_active <= w_active_nxt;
      r_drop   <= w_drop_nxt;
      r_supp   <= w_supp_nxt;
      r_rr     <= w_rr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign lat_inhibit    = r_lat;
  assign winner_valid   = r_valid;
  assign winner_idx     = r_idx;
  assign inhibit_active = r_active;
  assign drop_count     = r_drop;
  assign supp_count     = r_supp;

endmodule

// File: tb/tb_wta_inhibit_ctrl.sv
// Scoreboard bench for wta_inhibit_ctrl: a cycle model queues expected outputs per
// driven cycle; they are popped and compared one time unit after the edge.
module tb_wta_inhibit_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] spikes_in;
  logic [3:0] refrac_len;
  logic [3:0] lat_inhibit;
  logic       winner_valid;
  logic [1:0] winner_idx;
  logic       winner_ready;
  logic       inhibit_active;
  logic [7:0] drop_count;
  logic [7:0] supp_count;

  wta_inhibit_ctrl #(
    .NUM_NEURONS(4), .IDX_W(2), .CNT_W(4), .INHIBIT_WINNER(0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .spikes_in(spikes_in),
    .refrac_len(refrac_len), .lat_inhibit(lat_inhibit), .winner_valid(winner_valid),
    .winner_idx(winner_idx), .winner_ready(winner_ready), .inhibit_active(inhibit_active),
    .drop_count(drop_count), .supp_count(supp_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] lat;
    logic       valid;
    logic [1:0] idx;
    logic       active;
    logic [7:0] drop;
    logic [7:0] supp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   m_state, m_cnt, m_rr, m_idx, m_drop, m_supp;
  logic m_valid;
  logic [3:0] m_lat;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_rr = 0; m_idx = 0; m_drop = 0; m_supp = 0;
    m_valid = 1'b0; m_lat = 4'b0000;
  endtask

  task automatic model_step(input logic [3:0] sp, input logic en, input logic [3:0] rl,
                            input logic rdy);
    int  w;
    bit  found;
    bit  grant;
    grant = (m_state == 0) && en && (sp != 4'b0000);
    if (m_state == 1 && sp != 4'b0000 && m_supp < 255) m_supp++;
    if (grant) begin
      found = 1'b0;
      w = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && sp[(m_rr + k) % 4]) begin
          w = (m_rr + k) % 4;
          found = 1'b1;
        end
      end
      m_lat   = 4'b1111;
      m_lat[w] = 1'b0;
      m_cnt   = (rl == 4'd0) ? 0 : int'(rl) - 1;
      m_state = 1;
      m_rr    = (w + 1) % 4;
      if (!m_valid || rdy) begin
        m_idx   = w;
        m_valid = 1'b1;
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (m_state == 1) begin
        if (!en || m_cnt == 0) begin
          m_state = 0;
          m_lat   = 4'b0000;
        end else begin
          m_cnt--;
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] sp, input logic en, input logic [3:0] rl,
                      input logic rdy);
    exp_t e;
    spikes_in    = sp;
    enable       = en;
    refrac_len   = rl;
    winner_ready = rdy;
    model_step(sp, en, rl, rdy);
    e.lat    = m_lat;
    e.valid  = m_valid;
    e.idx    = 2'(m_idx);
    e.active = (m_state == 1);
    e.drop   = 8'(m_drop);
    e.supp   = 8'(m_supp);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val("lat_inhibit", 32'(lat_inhibit), 32'(e.lat));
      check_val("winner_valid", 32'(winner_valid), 32'(e.valid));
      check_val("winner_idx", 32'(winner_idx), 32'(e.idx));
      check_val("inhibit_active", 32'(inhibit_active), 32'(e.active));
      check_val("drop_count", 32'(drop_count), 32'(e.drop));
      check_val("supp_count", 32'(supp_count), 32'(e.supp));
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; spikes_in = 4'b0000; refrac_len = 4'd0; winner_ready = 1'b0;
    model_reset();
    #12;
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("rst_lat", 32'(lat_inhibit), 32'd0);
    check_val("rst_valid", 32'(winner_valid), 32'd0);
    check_val("rst_active", 32'(inhibit_active), 32'd0);

    // Single grant, 3-cycle window
    step(4'b0100, 1'b1, 4'd3, 1'b1);
    check_val("single_idx", 32'(winner_idx), 32'd2);
    check_val("single_lat", 32'(lat_inhibit), 32'hB);
    repeat (2) step(4'b0000, 1'b1, 4'd3, 1'b1);
    check_val("single_lat_3rd", 32'(lat_inhibit), 32'hB);
    step(4'b0000, 1'b1, 4'd3, 1'b1);
    check_val("single_lat_end", 32'(lat_inhibit), 32'h0);

    // Round-robin wrap
    step(4'b1001, 1'b1, 4'd3, 1'b1);
    check_val("rr_idx3", 32'(winner_idx), 32'd3);
    repeat (3) step(4'b0000, 1'b1, 4'd3, 1'b1);
    step(4'b1001, 1'b1, 4'd3, 1'b1);
    check_val("rr_idx0", 32'(winner_idx), 32'd0);
    repeat (3) step(4'b0000, 1'b1, 4'd3, 1'b1);

    // Suppression during window, then zero-length window
    step(4'b0010, 1'b1, 4'd4, 1'b1);
    repeat (3) step(4'b0001, 1'b1, 4'd4, 1'b1);
    check_val("supp_3", 32'(supp_count), 32'd3);
    check_val("supp_idx", 32'(winner_idx), 32'd1);
    step(4'b0000, 1'b1, 4'd4, 1'b1);
    step(4'b0100, 1'b1, 4'd0, 1'b1);
    check_val("rl0_lat", 32'(lat_inhibit), 32'hB);
    step(4'b0000, 1'b1, 4'd0, 1'b1);
    check_val("rl0_lat_end", 32'(lat_inhibit), 32'h0);

    // Backpressure drop, then grant coincident with transfer
    step(4'b0001, 1'b1, 4'd1, 1'b0);
    step(4'b0000, 1'b1, 4'd1, 1'b0);
    step(4'b0100, 1'b1, 4'd1, 1'b0);
    check_val("bp_idx", 32'(winner_idx), 32'd0);
    check_val("bp_drop", 32'(drop_count), 32'd1);
    check_val("bp_lat", 32'(lat_inhibit), 32'hB);
    step(4'b0000, 1'b1, 4'd1, 1'b0);
    step(4'b1000, 1'b1, 4'd1, 1'b1);
    check_val("bp_reload_idx", 32'(winner_idx), 32'd3);
    check_val("bp_reload_valid", 32'(winner_valid), 32'd1);
    step(4'b0000, 1'b1, 4'd1, 1'b1);

    // Enable abort mid-window, no grant while disabled
    step(4'b0001, 1'b1, 4'd5, 1'b1);
    step(4'b0000, 1'b1, 4'd5, 1'b1);
    step(4'b0000, 1'b0, 4'd5, 1'b1);
    check_val("abort_lat", 32'(lat_inhibit), 32'h0);
    step(4'b1111, 1'b0, 4'd5, 1'b1);
    check_val("dis_valid", 32'(winner_valid), 32'd0);
    check_val("dis_active", 32'(inhibit_active), 32'd0);

    // Asynchronous reset in the middle of a window
    step(4'b0100, 1'b1, 4'd6, 1'b1);
    step(4'b0000, 1'b1, 4'd6, 1'b0);
    reset = 1'b1;
    #2;
    check_val("arst_lat", 32'(lat_inhibit), 32'd0);
    check_val("arst_valid", 32'(winner_valid), 32'd0);
    check_val("arst_active", 32'(inhibit_active), 32'd0);
    check_val("arst_drop", 32'(drop_count), 32'd0);
    check_val("arst_supp", 32'(supp_count), 32'd0);
    check_val("arst_idx", 32'(winner_idx), 32'd0);
    model_reset();
    #2;
    reset = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 9) != 0),
           4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
